// File: rtl/djb2_stream.sv
// Streaming DJB2 hash: accepts BPB-byte beats, folds one byte lane per cycle,
// and presents the final hash and byte count for one message at a time.
module djb2_stream #(
    parameter int unsigned BPB    = 4,
    parameter int unsigned HASH_W = 32,
    parameter logic [HASH_W-1:0] SEED = HASH_W'(5381),
    parameter int unsigned MODE   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [8*BPB-1:0]    s_data,
    input  logic [BPB-1:0]      s_keep,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [HASH_W-1:0]   m_hash,
    output logic [31:0]         m_len,
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid is never withdrawn by this block until it is accepted.

    localparam int unsigned IDX_W = (BPB > 1) ? $clog2(BPB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPB - 1);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [HASH_W-1:0]    hash_q, hash_d;
    logic [31:0]          len_q, len_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [8*BPB-1:0]     data_q, data_d;
    logic [BPB-1:0]       keep_q, keep_d;
    logic                 last_q, last_d;

    logic [7:0]           cur_byte;
    logic                 cur_keep;
    logic [HASH_W-1:0]    mul33;
    logic [HASH_W-1:0]    byte_ext;

    always_comb begin
        cur_byte = 8'd0;
        cur_keep = 1'b0;
        for (int i = 0; i < BPB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_byte = data_q[8*i +: 8];
                cur_keep = keep_q[i];
            end
        end
    end

    // Multiply by 33 as shift-and-add; wraps silently at HASH_W bits.
    assign mul33    = (hash_q << 5) + hash_q;
    assign byte_ext = {{(HASH_W-8){1'b0}}, cur_byte};

    always_comb begin
        state_d = state_q;
        hash_d  = hash_q;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state_q)
            ACCEPT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    data_d  = s_data;
                    keep_d  = s_keep;
                    last_d  = s_last;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cur_keep) begin
                    hash_d = (MODE == 0) ? (mul33 + byte_ext) : (mul33 ^ byte_ext);
                    len_d  = len_q + 32'd1;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = last_q ? DONE : ACCEPT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    hash_d  = SEED;
                    len_d   = 32'd0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCEPT;
            hash_q  <= SEED;
            len_q   <= 32'd0;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hash_q  <= hash_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign m_hash    = hash_q;
    assign m_len     = len_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_djb2_stream.sv
// Directed bench for djb2_stream: add variant (dut) and xor variant (dut_x)
// share one stimulus stream and run in lockstep.
module tb_djb2_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic [3:0]  s_keep = 4'd0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready, m_valid, s_ready_x, m_valid_x;
    logic [31:0] m_hash, m_len, m_hash_x, m_len_x;
    logic [1:0]  dbg_state, dbg_state_x;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    djb2_stream #(.BPB(4), .HASH_W(32), .SEED(32'd5381), .MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_hash(m_hash), .m_len(m_len),
        .dbg_state(dbg_state)
    );

    djb2_stream #(.BPB(4), .HASH_W(32), .SEED(32'd5381), .MODE(1)) dut_x (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_x),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .m_valid(m_valid_x), .m_ready(m_ready), .m_hash(m_hash_x), .m_len(m_len_x),
        .dbg_state(dbg_state_x)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: waits (bounded) for s_ready, then presents one beat for one edge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (!s_ready) begin
            fails++;
            $display("FAIL send_ready_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
        s_keep  = 4'hF;
        s_last  = 1'b0;
    endtask

    // Counts edges after the accepting edge until m_valid rises (bounded).
    task automatic wait_valid(output int n);
        n = 1;
        tick();
        while (!m_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic pop_result();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: s_ready=%0b m_valid=%0b, required 1 0", s_ready, m_valid);
        end
        tests++;
        if (m_hash !== 32'h0000_1505 || m_len !== 32'd0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_values: hash=%h len=%0d state=%0d, required 00001505 0 0",
                     m_hash, m_len, dbg_state);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ab_single();
        int n;
        send_beat(32'h0000_6261, 4'b0011, 1'b1);
        wait_valid(n);
        tests++;
        if (n !== 4 || m_valid !== 1'b1) begin
            fails++;
            $display("FAIL ab_latency: edges=%0d m_valid=%0b, required 4 1", n, m_valid);
        end
        tests++;
        if (m_hash !== 32'h0059_7728 || m_len !== 32'd2) begin
            fails++;
            $display("FAIL ab_hash: hash=%h len=%0d, required 00597728 2", m_hash, m_len);
        end
        tests++;
        if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL ab_done_ready: s_ready=%0b, required 0", s_ready);
        end
        pop_result();
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_hash !== 32'h0000_1505 || m_len !== 32'd0) begin
            fails++;
            $display("FAIL ab_pop: m_valid=%0b s_ready=%0b hash=%h len=%0d, required 0 1 00001505 0",
                     m_valid, s_ready, m_hash, m_len);
        end
    endtask

    task automatic test_split();
        int n;
        send_beat(32'hAAAA_AA61, 4'b0001, 1'b0);
        send_beat(32'h5555_6255, 4'b0010, 1'b1);
        wait_valid(n);
        tests++;
        if (n !== 4 || m_hash !== 32'h0059_7728 || m_len !== 32'd2) begin
            fails++;
            $display("FAIL split_ab: edges=%0d hash=%h len=%0d, required 4 00597728 2", n, m_hash, m_len);
        end
        pop_result();
    endtask

    task automatic test_mode_variants();
        int n;
        send_beat(32'h0000_0061, 4'b0001, 1'b1);
        wait_valid(n);
        tests++;
        if (m_hash !== 32'h0002_B606 || m_len !== 32'd1) begin
            fails++;
            $display("FAIL add_a: hash=%h len=%0d, required 0002b606 1", m_hash, m_len);
        end
        tests++;
        if (m_valid_x !== 1'b1 || m_hash_x !== 32'h0002_B5C4 || m_len_x !== 32'd1) begin
            fails++;
            $display("FAIL xor_a: valid=%0b hash=%h len=%0d, required 1 0002b5c4 1",
                     m_valid_x, m_hash_x, m_len_x);
        end
        pop_result();
    endtask

    task automatic test_keep_patterns();
        int n;
        send_beat(32'h1234_5678, 4'b0000, 1'b1);
        wait_valid(n);
        tests++;
        if (n !== 4 || m_hash !== 32'h0000_1505 || m_len !== 32'd0) begin
            fails++;
            $display("FAIL empty_msg: edges=%0d hash=%h len=%0d, required 4 00001505 0", n, m_hash, m_len);
        end
        pop_result();
        send_beat(32'h0062_FF61, 4'b0101, 1'b1);
        wait_valid(n);
        tests++;
        if (m_hash !== 32'h0059_7728 || m_len !== 32'd2) begin
            fails++;
            $display("FAIL sparse_keep: hash=%h len=%0d, required 00597728 2", m_hash, m_len);
        end
        pop_result();
    endtask

    task automatic test_stall();
        int n;
        int bad = 0;
        send_beat(32'h0000_6261, 4'b0011, 1'b1);
        wait_valid(n);
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = $urandom_range(32'hFFFF_FFFF, 0);
            s_keep = 4'($urandom_range(15, 0));
            s_last = 1'($urandom_range(1, 0));
            tick();
            if (m_valid !== 1'b1 || m_hash !== 32'h0059_7728 || m_len !== 32'd2 || s_ready !== 1'b0)
                bad++;
        end
        s_valid = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
        end
        pop_result();
        send_beat(32'h0000_0061, 4'b0001, 1'b1);
        wait_valid(n);
        tests++;
        if (m_hash !== 32'h0002_B606 || m_len !== 32'd1) begin
            fails++;
            $display("FAIL stall_next_seed: hash=%h len=%0d, required 0002b606 1", m_hash, m_len);
        end
        pop_result();
    endtask

    task automatic test_reset_mid_shift();
        int n;
        int seen = 0;
        send_beat(32'h0000_6261, 4'b0011, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m_valid !== 1'b0) seen++;
            tick();
        end
        tests++;
        if (seen != 0 || m_hash !== 32'h0000_1505 || m_len !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_shift: valid_cycles=%0d hash=%h len=%0d, required 0 00001505 0",
                     seen, m_hash, m_len);
        end
        send_beat(32'h0000_0061, 4'b0001, 1'b1);
        wait_valid(n);
        tests++;
        if (n !== 4 || m_hash !== 32'h0002_B606 || m_len !== 32'd1) begin
            fails++;
            $display("FAIL after_reset_a: edges=%0d hash=%h len=%0d, required 4 0002b606 1", n, m_hash, m_len);
        end
        pop_result();
    endtask

    initial begin
        test_reset();
        test_ab_single();
        test_split();
        test_mode_variants();
        test_keep_patterns();
        test_stall();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/djb2_stream.md
DJB2_STREAM -- requirements
Module: djb2_stream

Interface
REQ-001 SHALL have parameter BPB, default 4, bytes per input beat (legal 1..8).
REQ-002 SHALL have parameter HASH_W, default 32, hash width (legal 32 or 64).
REQ-003 SHALL have parameter SEED, default 5381, initial hash value.
REQ-004 SHALL have parameter MODE, default 0: 0 = add variant (h*33+c), 1 = xor variant (h*33^c).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port s_valid  input  1  input beat valid.
REQ-008 SHALL have port s_ready  output  1  block can accept a beat.
REQ-009 SHALL have port s_data  input  8*BPB  message bytes; byte i = s_data[8i+7:8i], byte 0 processed first.
REQ-010 SHALL have port s_keep  input  BPB  byte i valid when s_keep[i]=1.
REQ-011 SHALL have port s_last  input  1  beat is final beat of message.
REQ-012 SHALL have port m_valid  output  1  hash result valid.
REQ-013 SHALL have port m_ready  input  1  downstream accepts result.
REQ-014 SHALL have port m_hash  output  HASH_W  final hash.
REQ-015 SHALL have port m_len  output  32  byte count of hashed message.

Function
REQ-016 SHALL implement FSM with states ACCEPT, SHIFT, DONE.
REQ-017 ACCEPT: s_ready=1, m_valid=0; s_valid&&s_ready at an edge SHALL capture s_data, s_keep, s_last, clear byte index to 0, go to SHIFT.
REQ-018 SHIFT: s_ready=0; one byte index per cycle, exactly BPB cycles, independent of s_keep (fixed latency).
REQ-019 In SHIFT, if keep[idx]=1, hash SHALL update to (hash*33)+byte (MODE=0) or (hash*33)^byte (MODE=1), mod 2^HASH_W, and length SHALL increment by 1 (mod 2^32); if keep[idx]=0, hash and length SHALL hold.
REQ-020 After idx=BPB-1: captured last=1 -> DONE; last=0 -> ACCEPT with hash and length retained.
REQ-021 Non-contiguous keep patterns SHALL be legal; only set bytes contribute, in ascending index order.
REQ-022 A beat with s_keep=0 SHALL be legal; with s_last=1 it yields hash=SEED-continued value (SEED for an empty message).
REQ-023 DONE: m_valid=1, m_hash=hash, m_len=length, stable while m_ready=0; s_ready=0.
REQ-024 DONE with m_ready=1 at an edge SHALL go to ACCEPT, load hash=SEED, length=0.
REQ-025 m_valid SHALL rise exactly BPB edges after the edge accepting the last beat.
REQ-026 s_valid/s_data SHALL be ignored when s_ready=0; m_ready ignored when m_valid=0.
REQ-027 Multiplication by 33 SHALL be realised as (hash<<5)+hash truncated to HASH_W; no overflow flag.

Reset
REQ-028 rst_n=0 at an edge SHALL force state ACCEPT, hash=SEED, length=0, idx=0, captured beat cleared.
REQ-029 During/after reset: s_ready=1, m_valid=0, m_hash=SEED, m_len=0.
REQ-030 Reset mid-SHIFT or in DONE SHALL discard partial message and pending result with no m_valid pulse.

Verification
REQ-031 BPB=4, MODE=0: one beat s_data=0x00006261, keep=0011, last=1 ("ab") -> m_valid 4 edges later, m_hash=0x00597728, m_len=2.
REQ-032 BPB=4, MODE=0: "a" as keep=0001 last=0, then keep=0010 byte1=0x62 last=1 -> m_hash=0x00597728, m_len=2 (split equals single beat).
REQ-033 MODE=1: "a" (0x61, keep=0001, last=1) -> m_hash=0x0002B5C4; MODE=0 same stimulus -> 0x0002B606.
REQ-034 keep=0000, last=1 -> m_hash=5381 (0x00001505), m_len=0; keep=0101 bytes 0x61,xx,0x62 -> same as "ab".
REQ-035 Hold m_ready=0 10 cycles in DONE -> m_valid, m_hash stable, s_ready=0, s_valid beats not accepted; m_ready=1 -> next message starts from SEED.
REQ-036 rst_n=0 for one cycle during SHIFT of "ab" -> no m_valid; subsequent "a" yields 0x0002B606.
